alu_div: RTL and testbench
==========================

# alu_div

Multi-cycle RV64M divide/remainder unit beside the combinational shifter in the core's ALU. Executes DIV, DIVU, REM, REMU and the 32-bit W variants with a radix-2 restoring shift-subtract loop, one quotient bit per cycle. Accepts one operation at a time through a valid/ready handshake from the execute stage and returns a 64-bit result through a second valid/ready handshake.

## Interface
- Parameters: none. Datapath width is `XLEN` (64) from sysconfig.v.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- div_valid  in  1  request valid.
- div_ready  out  1  unit idle; request accepted on the edge where div_valid & div_ready.
- div_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- div_rem  in  1  1 = return remainder, 0 = return quotient.
- isdiv32  in  1  W variant: use operand bits [31:0], sign-extend the 32-bit result to 64.
- dividend  in  `XLEN  rs1.
- divisor  in  `XLEN  rs2.
- flush  in  1  pipeline kill; aborts any operation in flight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result on the edge where out_valid & out_ready.
- div_out  out  `XLEN  result; held stable while out_valid & !out_ready.

## Operation
- States: IDLE, CALC, FIX, DONE. div_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE, accept: register |dividend| and |divisor| (magnitudes only when div_signed and sign bit set; sign bit is [31] when isdiv32, else [63]), quotient sign = sa ^ sb, remainder sign = sa, iteration counter = 32 or 64. Operands masked to [31:0] when isdiv32. Next state CALC.
- Accept with special case goes straight to DONE with result registered:
  - divisor == 0 (in the effective width): quotient = all ones; remainder = dividend (effective width).
  - signed, dividend = most-negative, divisor = -1: quotient = dividend; remainder = 0.
- CALC, each cycle: shift {rem, quo} left 1; if rem >= divisor then rem -= divisor, quo[0] = 1. Counter decrements; at 0 go to FIX.
- FIX: conditionally negate quotient/remainder by the stored signs, select by div_rem, sign-extend from bit 31 when isdiv32 (also for DIVUW/REMUW), register into div_out. Next DONE.
- DONE: hold div_out; on out_ready go to IDLE.
- flush: in any state, next edge goes to IDLE, out_valid low; flush has priority over accept and over out handshake. A request presented with flush high is not accepted.
- Reset: state = IDLE, div_ready = 1, out_valid = 0, div_out = 0, all datapath registers 0; asynchronous reset mid-operation discards it.

## Timing
- Normal op: accept on edge 0; CALC after edges 1..N (N = 64, or 32 for W); FIX → DONE on edge N+1; out_valid first high after edge N+1 (65 cycles for 64-bit, 33 for W).
- Special cases: out_valid high after edge 0 (1-cycle latency).
- No overlap: next request accepted no earlier than the edge after the out handshake.
- div_out changes only on the FIX→DONE or accept→DONE edge.

## Structure
- `XLEN` and any result-select macros stay in sysconfig.v; state encoding is local (2-bit localparams).
- One sub-module: div_negate (`XLEN` conditional two's complement, combinational), instantiated for operand magnitude and for result fixup.
- Single subtractor, shared by CALC compare and update (compare = carry-out).

## Test plan
- DIVU 100 / 7, 64-bit -> out_valid after 65 cycles, div_out = 14; same with div_rem -> 2.
- DIV -7 / 2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD); REM -7 % 2 -> -1 (all ones); REM 7 % -2 -> 1.
- DIVW 0x0000_0001_8000_0000 / 1 -> upper bits ignored, result 0xFFFF_FFFF_8000_0000 after 33 cycles; DIVUW same operands -> 0xFFFF_FFFF_8000_0000 (sign-extended).
- Divide by zero: DIVU 5 / 0 -> all ones, REMU -> 5, both with out_valid one cycle after accept; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, REM -> 0.
- Backpressure: hold out_ready low 10 cycles in DONE -> div_out stable, div_ready low; raise out_ready -> IDLE next cycle, div_ready high.
- Flush at CALC cycle 20, then rst_n pulse low mid-CALC on a second op -> IDLE each time, out_valid never asserted, following DIVU 9 / 3 returns 3.

Source files
------------

// File: rtl/alu_div_pkg.sv
// Shared types and constants for the alu_div divide/remainder unit.
// Datapath width, FSM state encoding and the 32-to-64 sign-extension helper.
package alu_div_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/alu_div_negate.sv
// Conditional two's complement of an XLEN-wide value (purely combinational).
module div_negate
  import alu_div_pkg::*;
(
  input  logic [XLEN-1:0] in_val,
  input  logic            neg,
  output logic [XLEN-1:0] out_val
);

  assign out_val = neg ? ((~in_val) + {{(XLEN-1){1'b0}}, 1'b1}) : in_val;

endmodule

// File: rtl/alu_div.sv
// RV64M divide/remainder unit: radix-2 restoring divider, one quotient bit per
// cycle, with valid/ready handshakes on both the request and result sides.
module alu_div
  import alu_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_rem,
  input  logic            isdiv32,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_out
);

  div_state_e       state_q, state_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             rsel_q, rsel_d;
  logic             w32_q, w32_d;
  logic [XLEN-1:0]  out_q, out_d;

  logic            accept;
  logic            sa, sb;
  logic [XLEN-1:0] a_ext, b_ext, a_w;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] special_res;
  logic [XLEN+1:0] diff;
  logic            ge;
  logic [XLEN-1:0] fix_in, fix_val;

  assign accept = div_valid & (state_q == ST_IDLE) & ~flush;

  // Operand views in the effective width; W ops look only at bits [31:0].
  assign sa    = div_signed & (isdiv32 ? dividend[31] : dividend[XLEN-1]);
  assign sb    = div_signed & (isdiv32 ? divisor[31]  : divisor[XLEN-1]);
  assign a_w   = isdiv32 ? sext32(dividend[31:0]) : dividend;
  assign a_ext = isdiv32 ? (div_signed ? sext32(dividend[31:0]) : {32'b0, dividend[31:0]}) : dividend;
  assign b_ext = isdiv32 ? (div_signed ? sext32(divisor[31:0])  : {32'b0, divisor[31:0]})  : divisor;

  div_negate u_neg_a (.in_val(a_ext), .neg(sa), .out_val(mag_a));
  div_negate u_neg_b (.in_val(b_ext), .neg(sb), .out_val(mag_b));

  assign b_zero = isdiv32 ? (divisor[31:0] == 32'd0) : (divisor == '0);
  assign ovf    = div_signed &
                  (isdiv32 ? ((dividend[31:0] == 32'h8000_0000) && (divisor[31:0] == 32'hFFFF_FFFF))
                           : ((dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1)));
  assign special = b_zero | ovf;

  always_comb begin
    special_res = '0;
    if (b_zero) begin
      special_res = div_rem ? a_w : '1;
    end else if (ovf) begin
      special_res = div_rem ? '0 : a_w;
    end
  end

  // One subtractor serves both the compare (sign of diff) and the update.
  assign diff = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, dvsr_q};
  assign ge   = ~diff[XLEN+1];

  assign fix_in = rsel_q ? rem_q : quo_q;
  div_negate u_neg_res (.in_val(fix_in), .neg(rsel_q ? rneg_q : qneg_q), .out_val(fix_val));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Outputs
  always_comb begin
    div_ready = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    div_out   = out_q;
  end

  // Datapath next values
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    rsel_d = rsel_q;
    w32_d  = w32_q;
    out_d  = out_q;
    if (accept) begin
      rem_d  = '0;
      // W dividends sit in the top half so 32 shifts bring them into rem.
      quo_d  = isdiv32 ? {mag_a[31:0], 32'b0} : mag_a;
      dvsr_d = isdiv32 ? {32'b0, mag_b[31:0]} : mag_b;
      cnt_d  = isdiv32 ? CNT_W'(32) : CNT_W'(64);
      qneg_d = sa ^ sb;
      rneg_d = sa;
      rsel_d = div_rem;
      w32_d  = isdiv32;
      if (special) out_d = special_res;
    end else if (state_q == ST_CALC) begin
      rem_d = ge ? diff[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_d = {quo_q[XLEN-2:0], ge};
      cnt_d = cnt_q - CNT_W'(1);
    end else if ((state_q == ST_FIX) && !flush) begin
      out_d = w32_q ? sext32(fix_val[31:0]) : fix_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rsel_q <= 1'b0;
      w32_q  <= 1'b0;
      out_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      rsel_q <= rsel_d;
      w32_q  <= w32_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed vector table, corner-case sequences
// and randomized operations against an arithmetic reference model.
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        div_signed = 1'b0;
  logic        div_rem = 1'b0;
  logic        isdiv32 = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] div_out;

  int checks = 0;
  int errors = 0;

  alu_div dut (
    .clk(clk), .rst_n(rst_n), .div_valid(div_valid), .div_ready(div_ready),
    .div_signed(div_signed), .div_rem(div_rem), .isdiv32(isdiv32),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .div_out(div_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    bit          rm;
    bit          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [63:0] model(bit s, bit r, bit w, logic [63:0] a, logic [63:0] b);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q64, r64;
    int          sa32, sb32;
    longint      sa64, sb64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (s) begin
        sa32 = int'(a32); sb32 = int'(b32);
        if (a32 == 32'h8000_0000 && sb32 == -1) begin
          q32 = a32; r32 = 0;
        end else begin
          q32 = 32'(sa32 / sb32); r32 = 32'(sa32 % sb32);
        end
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      return r ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    if (b == 0) begin
      q64 = '1; r64 = a;
    end else if (s) begin
      sa64 = longint'(a); sb64 = longint'(b);
      if (a == 64'h8000_0000_0000_0000 && sb64 == -1) begin
        q64 = a; r64 = 0;
      end else begin
        q64 = 64'(sa64 / sb64); r64 = 64'(sa64 % sb64);
      end
    end else begin
      q64 = a / b; r64 = a % b;
    end
    return r ? r64 : q64;
  endfunction

  function automatic int model_lat(bit s, bit w, logic [63:0] a, logic [63:0] b);
    logic [31:0] a32, b32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 0 || (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)) return 0;
      return 33;
    end
    if (b == 0 || (s && a == 64'h8000_0000_0000_0000 && b == '1)) return 0;
    return 65;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!div_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
  endtask

  // Issues one op, measures edges from accept to out_valid, then takes the result.
  task automatic run_op(input bit s, input bit r, input bit w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    wait_idle();
    div_signed = s; div_rem = r; isdiv32 = w; dividend = a; divisor = b;
    div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    res = div_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handshake_idle", {62'b0, div_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic [63:0] res, exp, held, a, b;
    int          lat, elat;
    bit          s, r, w, seen_valid;

    vecs[0]  = '{0, 0, 0, 64'd100, 64'd7, 64'd14, 65};
    vecs[1]  = '{0, 1, 0, 64'd100, 64'd7, 64'd2, 65};
    vecs[2]  = '{1, 0, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{1, 1, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{1, 1, 0, 64'd7, -64'sd2, 64'd1, 65};
    vecs[5]  = '{1, 0, 1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
    vecs[6]  = '{0, 0, 1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};
    vecs[7]  = '{0, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[8]  = '{0, 1, 0, 64'd5, 64'd0, 64'd5, 0};
    vecs[9]  = '{1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0};
    vecs[10] = '{1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_div_ready", {63'b0, div_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_div_out", div_out, 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].sgn, vecs[i].rm, vecs[i].w, vecs[i].a, vecs[i].b, res, lat);
      $display("vec %0d s=%0d r=%0d w=%0d a=%h b=%h -> %h lat=%0d", i, vecs[i].sgn,
               vecs[i].rm, vecs[i].w, vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: result must hold while the consumer stalls.
    wait_idle();
    div_signed = 0; div_rem = 0; isdiv32 = 0; dividend = 64'd1000; divisor = 64'd10;
    div_valid = 1'b1;
    @(posedge clk); #1 div_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    held = div_out;
    chk("bp_result", held, 64'd100);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_out", div_out, 64'd100);
      chk("bp_hold_state", {62'b0, div_ready, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("bp_release_ready", {63'b0, div_ready}, 64'd1);
    $display("backpressure op 1000/10 -> %h", held);

    // Flush mid-CALC, with a competing request that must be ignored.
    seen_valid = 0;
    div_signed = 0; div_rem = 0; isdiv32 = 0; dividend = 64'd123456789; divisor = 64'd3;
    div_valid = 1'b1;
    @(posedge clk); #1 div_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1; seen_valid |= out_valid;
    end
    flush = 1'b1; div_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; div_valid = 1'b0;
    chk("flush_idle", {62'b0, div_ready, out_valid}, 64'd2);
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1; seen_valid |= out_valid;
    end
    chk("flush_no_valid", {63'b0, seen_valid}, 64'd0);
    $display("flush at calc cycle 20 -> ready=%0d", div_ready);

    // Asynchronous reset mid-CALC on a second op.
    seen_valid = 0;
    dividend = 64'd987654321; divisor = 64'd7;
    div_valid = 1'b1;
    @(posedge clk); #1 div_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; seen_valid |= out_valid;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_idle", {62'b0, div_ready, out_valid}, 64'd2);
    chk("rst_div_out", div_out, 64'd0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1; seen_valid |= out_valid;
    end
    chk("rst_no_valid", {63'b0, seen_valid}, 64'd0);
    run_op(0, 0, 0, 64'd9, 64'd3, res, lat);
    $display("post-abort op 9/3 -> %h lat=%0d", res, lat);
    chk("post_abort_result", res, 64'd3);
    chk("post_abort_latency", 64'(lat), 64'd65);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = 64'd0;
        1: b = '1;
        2: b = 64'($urandom_range(1, 20));
        3: b = w ? {$urandom, 32'h0} : 64'd0;
        4: b = {32'h0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 7) == 0) a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      if ($urandom_range(0, 5) == 0) a = 64'($urandom_range(0, 1000));
      exp  = model(s, r, w, a, b);
      elat = model_lat(s, w, a, b);
      run_op(s, r, w, a, b, res, lat);
      $display("rnd %0d s=%0d r=%0d w=%0d a=%h b=%h -> %h lat=%0d", i, s, r, w, a, b, res, lat);
      chk($sformatf("rnd%0d_result", i), res, exp);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
